// File: rtl/reference_generator.sv
// Signed triangle-wave reference source for the IAGC loop, feeding the ZMOD DAC and amplitude detector.
// Latency: first o_sample D+1 clocks after leaving IDLE, then one sample every D+1 clocks.
// Backpressure: none; free-running source, status RESET stops it on the next edge.
module reference_generator #(
    parameter int IAGC_STATUS_SIZE    = 4,
    parameter int ZMOD_DATA_SIZE      = 14,
    parameter int AMPLITUDE_DATA_SIZE = 13,
    parameter int DIVIDER_SIZE        = 16
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0]       i_iagc_status,
    input  logic [AMPLITUDE_DATA_SIZE-1:0]    i_amplitude,
    input  logic [AMPLITUDE_DATA_SIZE-1:0]    i_step,
    input  logic [DIVIDER_SIZE-1:0]           i_sample_divider,
    output logic signed [ZMOD_DATA_SIZE-1:0]  o_reference,
    output logic                              o_sample,
    output logic                              o_cycle_done
);

    // One extra bit over the sample width so value +/- step can never wrap.
    localparam int NW = ZMOD_DATA_SIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RISE,
        S_FALL,
        S_RETURN
    } state_t;

    state_t                           state_q, state_d;
    logic [DIVIDER_SIZE-1:0]          cnt_q, cnt_d;
    logic [AMPLITUDE_DATA_SIZE-1:0]   amp_q, step_q;
    logic signed [ZMOD_DATA_SIZE-1:0] value_d;
    logic                             sample_d, done_d, latch;

    logic        status_rst, strobe, in_zero;
    logic signed [NW-1:0] val_s, amp_s, neg_amp_s, step_s, up_s, dn_s;

    assign status_rst = (i_iagc_status == '0);
    assign strobe     = (state_q != S_IDLE) && (cnt_q == i_sample_divider);
    // Decisions at a latch point look at the values being latched right now.
    assign in_zero    = (i_amplitude == '0) || (i_step == '0);

    assign val_s     = $signed({o_reference[ZMOD_DATA_SIZE-1], o_reference});
    assign amp_s     = $signed(NW'(amp_q));
    assign step_s    = $signed(NW'(step_q));
    assign neg_amp_s = -amp_s;
    assign up_s      = val_s + step_s;
    assign dn_s      = val_s - step_s;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        if (status_rst) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            latch   = 1'b1;
            state_d = in_zero ? S_HOLD : S_RISE;
        end else if (strobe) begin
            case (state_q)
                S_RISE:   if (up_s >= amp_s)     state_d = S_FALL;
                S_FALL:   if (dn_s <= neg_amp_s) state_d = S_RETURN;
                S_RETURN: begin
                    if (!up_s[NW-1]) begin
                        latch   = 1'b1;
                        state_d = in_zero ? S_HOLD : S_RISE;
                    end
                end
                S_HOLD: begin
                    latch   = 1'b1;
                    state_d = in_zero ? S_HOLD : S_RISE;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        value_d  = o_reference;
        sample_d = 1'b0;
        done_d   = 1'b0;
        if (status_rst || state_q == S_IDLE) begin
            value_d = '0;
        end else if (strobe) begin
            sample_d = 1'b1;
            case (state_q)
                S_RISE:   value_d = (up_s >= amp_s) ? amp_s[ZMOD_DATA_SIZE-1:0]
                                                    : up_s[ZMOD_DATA_SIZE-1:0];
                S_FALL:   value_d = (dn_s <= neg_amp_s) ? neg_amp_s[ZMOD_DATA_SIZE-1:0]
                                                        : dn_s[ZMOD_DATA_SIZE-1:0];
                S_RETURN: begin
                    if (!up_s[NW-1]) begin
                        value_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        value_d = up_s[ZMOD_DATA_SIZE-1:0];
                    end
                end
                default:  value_d = '0;
            endcase
        end
    end

    // Counter sits at zero in IDLE so the first strobe lands D+1 clocks after exit.
    always_comb begin
        if (status_rst || state_q == S_IDLE || strobe) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIVIDER_SIZE'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q        <= '0;
            amp_q        <= '0;
            step_q       <= '0;
            o_reference  <= '0;
            o_sample     <= 1'b0;
            o_cycle_done <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            o_reference  <= value_d;
            o_sample     <= sample_d;
            o_cycle_done <= done_d;
            if (latch) begin
                amp_q  <= i_amplitude;
                step_q <= i_step;
            end
        end
    end

endmodule

// File: tb/tb_reference_generator.sv
// Directed and randomized checks of reference_generator against a per-period sample-list model.
module tb_reference_generator;

    typedef int iq_t[$];

    logic               i_clock = 1'b0;
    logic               i_reset_n;
    logic [3:0]         i_iagc_status;
    logic [12:0]        i_amplitude;
    logic [12:0]        i_step;
    logic [15:0]        i_sample_divider;
    logic signed [13:0] o_reference;
    logic               o_sample;
    logic               o_cycle_done;

    int tests = 0;
    int fails = 0;
    int last_ref = 0;

    always #5 i_clock = ~i_clock;

    reference_generator dut (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .i_iagc_status    (i_iagc_status),
        .i_amplitude      (i_amplitude),
        .i_step           (i_step),
        .i_sample_divider (i_sample_divider),
        .o_reference      (o_reference),
        .o_sample         (o_sample),
        .o_cycle_done     (o_cycle_done)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One triangle period as a list of samples: ramp up to +a, down to -a, back to 0.
    function automatic iq_t period_model(input int a, input int s);
        iq_t q;
        int  v;
        q = {};
        v = 0;
        do begin v = v + s; if (v >= a) v = a; q.push_back(v); end while (v < a);
        do begin v = v - s; if (v <= -a) v = -a; q.push_back(v); end while (v > -a);
        do begin v = v + s; if (v >= 0) v = 0; q.push_back(v); end while (v < 0);
        return q;
    endfunction

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_sample(output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
            if (!o_sample) begin
                chk("between_ref", o_reference, last_ref);
                chk("between_done", o_cycle_done, 0);
            end
        end while (!o_sample && gap < 40);
        if (!o_sample) chk("sample_timeout", 0, 1);
    endtask

    task automatic expect_sample(input string tag, input int val, input bit done, input int gap_exp);
        int g;
        wait_sample(g);
        chk({tag, "_gap"}, g, gap_exp);
        chk({tag, "_ref"}, o_reference, val);
        chk({tag, "_done"}, o_cycle_done, done);
        last_ref = val;
    endtask

    task automatic run_samples(input string tag, input iq_t q, input int lo, input int hi,
                               input int d, input int first_gap);
        for (int i = lo; i < hi; i++) begin
            expect_sample(tag, q[i], (i == q.size() - 1), (i == lo) ? first_gap : d + 1);
        end
    endtask

    task automatic go_idle;
        i_iagc_status = 4'b0000;
        tick();
        chk("idle_ref", o_reference, 0);
        chk("idle_sample", o_sample, 0);
        chk("idle_done", o_cycle_done, 0);
        last_ref = 0;
    endtask

    task automatic start(input int a, input int s, input int d);
        go_idle();
        i_amplitude      = 13'(a);
        i_step           = 13'(s);
        i_sample_divider = 16'(d);
        i_iagc_status    = 4'b0001;
    endtask

    initial begin
        iq_t q, q2;
        int  a, s, d;

        i_reset_n        = 1'b0;
        i_iagc_status    = 4'b0000;
        i_amplitude      = '0;
        i_step           = '0;
        i_sample_divider = '0;
        #12;
        chk("rst_ref", o_reference, 0);
        chk("rst_sample", o_sample, 0);
        chk("rst_done", o_cycle_done, 0);
        @(negedge i_clock);
        i_reset_n = 1'b1;

        // Basic triangle, two full periods back to back.
        start(100, 25, 0);
        q = period_model(100, 25);
        run_samples("basic", q, 0, q.size(), 0, 2);
        run_samples("basic2", q, 0, q.size(), 0, 1);

        // Step not dividing amplitude: peaks clamp to +/-amp.
        start(100, 30, 0);
        q = period_model(100, 30);
        run_samples("clamp", q, 0, q.size(), 0, 2);
        run_samples("clamp2", q, 0, q.size(), 0, 1);

        // Divider D=3: strobe every 4 clocks, first one 4 clocks after IDLE exit.
        start(100, 25, 3);
        q = period_model(100, 25);
        run_samples("div", q, 0, q.size(), 3, 5);
        run_samples("div2", q, 0, 4, 3, 4);

        // Amplitude change mid-period only takes effect from the next period.
        start(100, 25, 0);
        q = period_model(100, 25);
        run_samples("mid_a", q, 0, 5, 0, 2);
        i_amplitude = 13'd50;
        run_samples("mid_b", q, 5, q.size(), 0, 1);
        q2 = period_model(50, 25);
        run_samples("mid_c", q2, 0, q2.size(), 0, 1);

        // Zero step holds at 0 while strobing, then rises once step is set.
        start(100, 0, 1);
        for (int i = 0; i < 4; i++) expect_sample("zero", 0, 1'b0, (i == 0) ? 3 : 2);
        i_step = 13'd25;
        expect_sample("zero_exit", 0, 1'b0, 2);
        q = period_model(100, 25);
        run_samples("zero_rise", q, 0, q.size(), 1, 2);

        // Status RESET at -75, then async reset mid-waveform, then restart from 25.
        start(100, 25, 0);
        q = period_model(100, 25);
        run_samples("rst_mid", q, 0, 11, 0, 2);
        go_idle();
        i_iagc_status = 4'b0001;
        run_samples("rst_restart", q, 0, 6, 0, 2);
        i_reset_n = 1'b0;
        #1;
        chk("arst_ref", o_reference, 0);
        chk("arst_sample", o_sample, 0);
        chk("arst_done", o_cycle_done, 0);
        #1;
        i_reset_n = 1'b1;
        last_ref  = 0;
        run_samples("arst_restart", q, 0, q.size(), 0, 2);

        // Full-scale boundaries.
        start(8191, 8191, 0);
        q = period_model(8191, 8191);
        run_samples("full_step", q, 0, q.size(), 0, 2);
        start(8191, 4000, 2);
        q = period_model(8191, 4000);
        run_samples("full_amp", q, 0, q.size(), 2, 4);

        // Randomized parameter sets, two periods each.
        for (int r = 0; r < 6; r++) begin
            a = int'($urandom_range(1, 8191));
            s = int'($urandom_range(a / 5 + 1, 8191));
            d = int'($urandom_range(0, 3));
            start(a, s, d);
            q = period_model(a, s);
            run_samples("rand", q, 0, q.size(), d, d + 2);
            run_samples("rand2", q, 0, q.size(), d, d + 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reference_generator.md
# reference_generator

Synthesizes the signed triangle-wave reference that the IAGC loop drives into the ZMOD DAC, at a programmed peak amplitude and slope, with a programmable sample rate. It is the source-side counterpart of the amplitude detector: the detector measures peak amplitude from sampled data, and this block produces sampled data of a requested peak amplitude. Its `o_sample` and `o_reference` outputs feed the DAC path and the detector's `i_sample` and `i_reference` inputs directly.

## Interface
- `IAGC_STATUS_SIZE`, 4: width of the IAGC status word.
- `ZMOD_DATA_SIZE`, 14: signed sample width.
- `AMPLITUDE_DATA_SIZE`, 13: unsigned amplitude and step width.
- `DIVIDER_SIZE`, 16: sample-divider width.

Ports:
- `i_clock`  in  1  single clock domain.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `i_iagc_status`  in  4  IAGC status; `4'b0000` = RESET.
- `i_amplitude`  in  13  requested peak amplitude, unsigned.
- `i_step`  in  13  per-sample increment, unsigned.
- `i_sample_divider`  in  16  D; one sample is produced every D+1 clocks.
- `o_reference`  out  14  signed sample, registered.
- `o_sample`  out  1  one-clock strobe; `o_reference` is new in the same cycle.
- `o_cycle_done`  out  1  one-clock pulse coincident with the `o_sample` that completes a period.

## Operation
- **States:** IDLE, HOLD, RISE, FALL, RETURN.
- **Latched parameters:** `amp` and `step` are the only values used for arithmetic. Inputs are sampled only at latch points, so changes mid-period have no effect until the next latch point.
- **Latch points:** IDLE exit, every HOLD strobe, and every `o_cycle_done`.
- **IDLE:**
  - `o_reference` = 0; the divider counter is held at 0.
  - When status ≠ RESET: latch parameters and go to RISE. If either latched value is 0, go to HOLD instead.
- **Divider:** counter increments every clock outside IDLE. When it equals D it wraps to 0 and produces a strobe. With D=0, every clock is a strobe.
- **Per strobe, by state.** `next` is computed in a 15-bit signed intermediate so it cannot overflow.
  - RISE: `next` = value + step. If `next` ≥ amp, then value = amp and go to FALL; else value = `next`.
  - FALL: `next` = value − step. If `next` ≤ −amp, then value = −amp and go to RETURN; else value = `next`.
  - RETURN: `next` = value + step. If `next` ≥ 0, then value = 0, assert `o_cycle_done`, re-latch, and go to RISE (or HOLD on a zero parameter); else value = `next`.
  - HOLD: value = 0; re-latch; go to RISE if both latched values are nonzero.
- **Status RESET:** when `i_iagc_status` = RESET in any state, the next edge forces IDLE, value 0, counter 0, and both strobes 0. This takes priority over a strobe in the same cycle.
- **Range:** amp up to 8191 is legal. ±8191 fits in `ZMOD_DATA_SIZE`. No other saturation is needed.

## Timing
- **Async reset** (`i_reset_n` = 0): state IDLE, `o_reference` = 0, `o_sample` = 0, `o_cycle_done` = 0, counter = 0, `amp`/`step` = 0. Effect is immediate, independent of the clock.
- **Start-up:** status leaves RESET before edge t. IDLE→RISE occurs at edge t. The first `o_sample` occurs at edge t+D+1, carrying value `step` (or `amp` if clamped).
- **Strobe outputs:** `o_sample` and `o_cycle_done` are registered, each high for exactly one clock. `o_cycle_done` is never high without `o_sample`.
- **Clamping:** each clamp consumes exactly one sample. The peak sample equals ±amp exactly, whatever `step` is.
- **Period length:** for step dividing amp, one period is 4·amp/step samples.

## Test plan
- **Basic triangle:** amp=100, step=25, D=0, status=`4'b0001` -> `o_sample` every clock. Samples are 25,50,75,100,75,…,−100,−75,−50,−25,0. `o_cycle_done` fires only on the 0, which is sample 16, and the pattern repeats.
- **Clamping:** amp=100, step=30 -> 30,60,90,100,70,40,10,−20,−50,−80,−100,−70,−40,−10,0 with `o_cycle_done`.
- **Divider:** D=3 -> `o_sample` exactly every 4 clocks. `o_reference` is constant between strobes. The first strobe is 4 clocks after leaving IDLE.
- **Mid-period change:** change amp from 100 to 50 at sample 5 -> the current period still peaks at ±100. The next period peaks at ±50.
- **Zero parameters:** step=0 -> `o_sample` continues and `o_reference` = 0 with no `o_cycle_done`. Setting step=25 -> RISE begins on the following strobe.
- **Reset mid-waveform:** with `o_reference` = −75, driving status=`4'b0000` returns outputs to 0 after one edge. Pulsing `i_reset_n` low clears the outputs asynchronously. After release, the waveform restarts from 25.
